// File: rtl/hex_scan_counter_pkg.sv
// Shared constants and helpers for the hex scan counter: derived widths and
// the segment polarity used by every display block.
package hex_scan_counter_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  // Segment drive polarity; 0 = segment lit when its bit is 1.
  localparam bit SEG_ACTIVE_LOW = 1'b0;

  // Raw (active-high) a..g pattern for digit 0, used as the reset display value.
  localparam logic [0:6] SEG_ZERO_RAW = 7'b1111110;

  function automatic int unsigned cw_of(input int unsigned digits);
    return NIB_W * digits;
  endfunction

  function automatic int unsigned idx_w_of(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/hex_scan_counter_if.sv
// Control/status bundle of the hex scan counter: count controls in, count,
// pulses and display drive out.
interface hex_scan_counter_if #(
  parameter int unsigned DIGITS = 4
);
  import hex_scan_counter_pkg::*;

  localparam int unsigned CW = cw_of(DIGITS);

  logic              en;
  logic              up;
  logic              clr;
  logic              load;
  logic [CW-1:0]     load_val;
  logic [CW-1:0]     count;
  logic              tick;
  logic              wrap;
  logic [0:6]        seg;
  logic [DIGITS-1:0] an;
  logic [3:0]        Led;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tick, wrap, seg, an, Led
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tick, wrap, seg, an, Led
  );

endinterface

// File: rtl/hex2_7seg_lut.sv
// Hex nibble to 7-segment decoder; seg_c[0] is segment a, seg_c[6] is segment g.
module hex2_7seg_lut
  import hex_scan_counter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg_c
);

  logic [0:6] raw_c;

  always_comb begin
    raw_c = 7'b0000000;
    unique case (nibble)
      4'h0: raw_c = 7'b1111110;
      4'h1: raw_c = 7'b0110000;
      4'h2: raw_c = 7'b1101101;
      4'h3: raw_c = 7'b1111001;
      4'h4: raw_c = 7'b0110011;
      4'h5: raw_c = 7'b1011011;
      4'h6: raw_c = 7'b1011111;
      4'h7: raw_c = 7'b1110000;
      4'h8: raw_c = 7'b1111111;
      4'h9: raw_c = 7'b1111011;
      4'hA: raw_c = 7'b1110111;
      4'hB: raw_c = 7'b0011111;
      4'hC: raw_c = 7'b1001110;
      4'hD: raw_c = 7'b0111101;
      4'hE: raw_c = 7'b1001111;
      4'hF: raw_c = 7'b1000111;
      default: raw_c = 7'b0000000;
    endcase
    seg_c = raw_c ^ {SEG_W{SEG_ACTIVE_LOW}};
  end

endmodule

// File: rtl/hex_scan_counter_tick_gen.sv
// Modulo-N enable-pulse generator: pulse_c is high on the last of every N
// enabled cycles; restart returns the phase to 0 and suppresses the pulse.
module hex_scan_counter_tick_gen #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic pulse_c
);

  localparam int unsigned     PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0]   LAST = PW'(N - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_c = en && !restart && (cnt_q == LAST);
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_counter.sv
// Prescaled up/down hex counter with load/clear and a time-multiplexed
// 7-segment display drive (one anode per digit, optional leading-zero blanking).
module hex_scan_counter
  import hex_scan_counter_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SCAN_DIV = 12500,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic              CLK1,
  input  logic              arst_n,
  hex_scan_counter_if.slave bus
);

  localparam int unsigned CW = cw_of(DIGITS);
  localparam int unsigned IW = idx_w_of(DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic              step_c;
  logic              scan_c;
  logic              restart_c;

  logic [CW-1:0]     count_q, count_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [0:6]        seg_q, seg_d;

  logic [CW-1:0]     shifted_c;
  logic [3:0]        nibble_c;
  logic              blank_c;
  logic [0:6]        lut_seg_c;

  assign restart_c = bus.clr | bus.load;

  hex_scan_counter_tick_gen #(.N(TICK_DIV)) u_step (
    .clk     (CLK1),
    .rst_n   (arst_n),
    .en      (bus.en),
    .restart (restart_c),
    .pulse_c (step_c)
  );

  hex_scan_counter_tick_gen #(.N(SCAN_DIV)) u_scan (
    .clk     (CLK1),
    .rst_n   (arst_n),
    .en      (1'b1),
    .restart (1'b0),
    .pulse_c (scan_c)
  );

  hex2_7seg_lut u_lut (
    .nibble (nibble_c),
    .seg_c  (lut_seg_c)
  );

  // Count update: clr beats load beats a prescaler step.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (step_c) begin
      tick_d = 1'b1;
      if (bus.up) begin
        count_d = count_q + CW'(1);
        wrap_d  = &count_q;
      end else begin
        count_d = count_q - CW'(1);
        wrap_d  = (count_q == '0);
      end
    end
  end

  // Display: the shifted count gives both the active nibble and the
  // "all higher digits zero" test used for leading-zero blanking.
  always_comb begin
    idx_d     = idx_q;
    if (scan_c) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    shifted_c = count_q >> {idx_q, 2'b00};
    nibble_c  = shifted_c[3:0];
    blank_c   = (BLANK_LZ != 0) && (idx_q != '0) && (shifted_c == '0);
    an_d      = blank_c ? '1 : ~(DIGITS'(1) << idx_q);
    seg_d     = lut_seg_c;
  end

  always_ff @(posedge CLK1 or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      idx_q   <= '0;
      an_q    <= ~(DIGITS'(1));
      seg_q   <= SEG_ZERO_RAW ^ {SEG_W{SEG_ACTIVE_LOW}};
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.Led   = count_q[3:0];

endmodule
